ex_muldiv: RTL and testbench

Iterative RV32M/RV64M multiply-divide execute unit. It sits in the EX stage beside the main ALU and has its own MEM/WB operand forwarding. It accepts one M-extension op, holds the pipeline with a stall while it iterates, and then presents a single-cycle result to the EX/MEM register. Data width is generalised through XLEN.

---
 rtl/ex_muldiv.sv | 164 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Shift-add multiplier and restoring divider share one 2*XLEN working register.
module ex_muldiv #(
    parameter int XLEN     = 32,
    parameter int RS_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic                flush,
    input  logic [2:0]          funct3,
    input  logic [RS_WIDTH-1:0] rs1,
    input  logic [RS_WIDTH-1:0] rs2,
    input  logic [XLEN-1:0]     read_data1,
    input  logic [XLEN-1:0]     read_data2,
    input  logic [RS_WIDTH-1:0] rd_mem,
    input  logic [RS_WIDTH-1:0] rd_wb,
    input  logic                regwrite_mem,
    input  logic                regwrite_wb,
    input  logic [XLEN-1:0]     wb_data_mem,
    input  logic [XLEN-1:0]     write_data_wb,
    output logic                stall,
    output logic                done,
    output logic [XLEN-1:0]     result
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [2:0]          funct3_reg;
    logic                neg_reg;
    logic [XLEN-1:0]     mcand_reg;
    logic [2*XLEN-1:0]   prod_reg;
    logic                done_reg;
    logic [XLEN-1:0]     result_reg;

    logic [RS_WIDTH-1:0] rs_idx   [2];
    logic [XLEN-1:0]     rf_val   [2];
    logic [XLEN-1:0]     fwd_val  [2];

    assign rs_idx[0] = rs1;
    assign rs_idx[1] = rs2;
    assign rf_val[0] = read_data1;
    assign rf_val[1] = read_data2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            // MEM is younger than WB, so it wins when both target the register
            assign fwd_val[gi] =
                (regwrite_mem && rd_mem == rs_idx[gi] && rd_mem != '0) ? wb_data_mem   :
                (regwrite_wb  && rd_wb  == rs_idx[gi] && rd_wb  != '0) ? write_data_wb :
                                                                          rf_val[gi];
        end
    endgenerate

    logic [XLEN-1:0] op1, op2, mag1, mag2, special_result;
    logic            is_div, sign1, sign2, div_zero, div_ovf, neg_next;

    always_comb begin
        op1      = fwd_val[0];
        op2      = fwd_val[1];
        is_div   = funct3[2];
        // MULHSU keeps rs1 signed; MULHU and the unsigned divides drop both signs
        sign1    = op1[XLEN-1] & (is_div ? ~funct3[0] : (funct3 != 3'b011));
        sign2    = op2[XLEN-1] & (is_div ? ~funct3[0] : ~funct3[1]);
        mag1     = sign1 ? -op1 : op1;
        mag2     = sign2 ? -op2 : op2;
        div_zero = is_div && (op2 == '0);
        div_ovf  = is_div && !funct3[0] && (op1 == XMIN) && (op2 == '1);
        neg_next = (is_div && funct3[1]) ? sign1 : (sign1 ^ sign2);
        if (div_zero)
            special_result = funct3[1] ? op1 : '1;
        else
            special_result = funct3[1] ? '0 : XMIN;
    end

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_next, prod_signed;
    logic [XLEN-1:0]   div_sel, final_result;

    always_comb begin
        mul_sum   = {1'b0, prod_reg[2*XLEN-1:XLEN]} +
                    (prod_reg[0] ? {1'b0, mcand_reg} : '0);
        // Restoring step: remainder in the high half, dividend/quotient shifts through the low half
        div_shift = {prod_reg[2*XLEN-1:XLEN], prod_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_reg};
        if (funct3_reg[2])
            prod_next = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_reg[XLEN-2:0], 1'b0}
                                       : {div_diff[XLEN-1:0],  prod_reg[XLEN-2:0], 1'b1};
        else
            prod_next = {mul_sum, prod_reg[XLEN-1:1]};
        prod_signed = neg_reg ? -prod_next : prod_next;
        div_sel     = funct3_reg[1] ? prod_next[2*XLEN-1:XLEN] : prod_next[XLEN-1:0];
        if (funct3_reg[2])
            final_result = neg_reg ? -div_sel : div_sel;
        else if (funct3_reg[1:0] == 2'b00)
            final_result = prod_signed[XLEN-1:0];
        else
            final_result = prod_signed[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            funct3_reg <= '0;
            neg_reg    <= 1'b0;
            mcand_reg  <= '0;
            prod_reg   <= '0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (valid && !flush) begin
                        funct3_reg <= funct3;
                        neg_reg    <= neg_next;
                        if (div_zero || div_ovf) begin
                            state_reg  <= DONE;
                            done_reg   <= 1'b1;
                            result_reg <= special_result;
                        end else begin
                            state_reg <= CALC;
                            count_reg <= CNT_W'(XLEN - 1);
                            mcand_reg <= is_div ? mag2 : mag1;
                            prod_reg  <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_reg  <= IDLE;
                        count_reg  <= '0;
                        funct3_reg <= '0;
                        neg_reg    <= 1'b0;
                        mcand_reg  <= '0;
                        prod_reg   <= '0;
                    end else begin
                        prod_reg <= prod_next;
                        if (count_reg == '0) begin
                            state_reg  <= DONE;
                            done_reg   <= 1'b1;
                            result_reg <= final_result;
                        end else begin
                            count_reg <= count_reg - 1'b1;
                        end
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign stall  = !rst && !flush && ((state_reg == IDLE && valid) || state_reg == CALC);
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases, forwarding, flush,
// asynchronous reset and randomized ops against an arithmetic reference model.
module tb_ex_muldiv;
    localparam int XLEN     = 32;
    localparam int RS_WIDTH = 5;
    localparam logic [31:0] XMIN = 32'h8000_0000;

    logic                clk = 1'b0;
    logic                rst;
    logic                valid, flush;
    logic [2:0]          funct3;
    logic [RS_WIDTH-1:0] rs1, rs2, rd_mem, rd_wb;
    logic [XLEN-1:0]     read_data1, read_data2, wb_data_mem, write_data_wb;
    logic                regwrite_mem, regwrite_wb;
    logic                stall, done;
    logic [XLEN-1:0]     result;

    int n_checks = 0;
    int n_fail   = 0;

    ex_muldiv #(.XLEN(XLEN), .RS_WIDTH(RS_WIDTH)) dut (
        .clk(clk), .rst(rst), .valid(valid), .flush(flush), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .read_data1(read_data1), .read_data2(read_data2),
        .rd_mem(rd_mem), .rd_wb(rd_wb), .regwrite_mem(regwrite_mem),
        .regwrite_wb(regwrite_wb), .wb_data_mem(wb_data_mem),
        .write_data_wb(write_data_wb), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // RV32M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_muldiv(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        logic [63:0]     p;
        logic            ovf = (a == XMIN) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = ua * ub;            return p[31:0];  end
            3'd1: begin p = sa * sb;            return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
            3'd3: begin p = ua * ub;            return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return XMIN;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] fwd_model(input logic [4:0] rs, input logic [31:0] rf);
        if (rs != 0 && regwrite_mem && rd_mem == rs) return wb_data_mem;
        if (rs != 0 && regwrite_wb && rd_wb == rs) return write_data_wb;
        return rf;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return XMIN;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Starts in an IDLE cycle at negedge; returns in the IDLE cycle after done
    task automatic run_op(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] exp, input string tag);
        logic [31:0] a, b;
        bit          special;
        int          lat;
        funct3 = f3; rs1 = r1; rs2 = r2; read_data1 = d1; read_data2 = d2; valid = 1'b1;
        a = fwd_model(r1, d1);
        b = fwd_model(r2, d2);
        special = f3[2] && (b == 0 || (!f3[0] && a == XMIN && b == 32'hFFFF_FFFF));
        #1;
        check_val({tag, " stall_accept"}, stall, 1);
        check_val({tag, " done_accept"}, done, 0);
        @(negedge clk);
        valid = 1'b0;
        // Operands must have been captured at the accept edge only
        read_data1 = $urandom; read_data2 = $urandom;
        wb_data_mem = $urandom; write_data_wb = $urandom;
        lat = 1;
        while (!done && lat < 60) begin
            check_val({tag, " stall_busy"}, stall, 1);
            @(negedge clk);
            lat++;
        end
        check_val({tag, " latency"}, lat, special ? 1 : XLEN + 1);
        check_val({tag, " result"}, result, exp);
        check_val({tag, " stall_done"}, stall, 0);
        $display("op %-14s f3=%0d a=0x%08h b=0x%08h result=0x%08h exp=0x%08h lat=%0d",
                 tag, f3, a, b, result, exp, lat);
        @(negedge clk);
        check_val({tag, " done_single"}, done, 0);
    endtask

    task automatic no_fwd();
        regwrite_mem = 1'b0; regwrite_wb = 1'b0; rd_mem = '0; rd_wb = '0;
    endtask

    initial begin
        int pulses;
        logic [2:0]  f3;
        logic [4:0]  r1, r2;
        logic [31:0] d1, d2, exp;

        rst = 1'b1; valid = 1'b1; flush = 1'b0; funct3 = '0; rs1 = 5'd1; rs2 = 5'd2;
        read_data1 = 32'd3; read_data2 = 32'd4; wb_data_mem = '0; write_data_wb = '0;
        no_fwd();
        #12;
        check_val("reset stall", stall, 0);
        check_val("reset done", done, 0);
        check_val("reset result", result, 0);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        @(negedge clk);

        run_op(3'd0, 5'd1, 5'd2, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3");
        run_op(3'd1, 5'd1, 5'd2, XMIN,         XMIN,          32'h4000_0000, "MULH min*min");
        run_op(3'd3, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU");
        run_op(3'd2, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU");
        run_op(3'd4, 5'd1, 5'd2, 32'd5,        32'd0,         32'hFFFF_FFFF, "DIV 5/0");
        run_op(3'd7, 5'd1, 5'd2, 32'd5,        32'd0,         32'd5,         "REMU 5/0");
        run_op(3'd4, 5'd1, 5'd2, XMIN,         32'hFFFF_FFFF, XMIN,          "DIV ovf");
        run_op(3'd6, 5'd1, 5'd2, XMIN,         32'hFFFF_FFFF, 32'd0,         "REM ovf");
        run_op(3'd4, 5'd1, 5'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "DIV -7/2");
        run_op(3'd6, 5'd1, 5'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "REM -7/2");
        run_op(3'd5, 5'd1, 5'd2, 32'd100,      32'd7,         32'd14,        "DIVU 100/7");
        run_op(3'd7, 5'd1, 5'd2, 32'd100,      32'd7,         32'd2,         "REMU 100/7");

        // Forwarding priority
        rd_mem = 5'd5; rd_wb = 5'd5; regwrite_mem = 1'b1; regwrite_wb = 1'b1;
        wb_data_mem = 32'h0000_1234; write_data_wb = 32'h0000_5678;
        run_op(3'd0, 5'd5, 5'd6, 32'h0000_9ABC, 32'd1, 32'h0000_1234, "FWD mem");
        rd_mem = 5'd5; rd_wb = 5'd5; regwrite_mem = 1'b0; regwrite_wb = 1'b1;
        wb_data_mem = 32'h0000_1234; write_data_wb = 32'h0000_5678;
        run_op(3'd0, 5'd5, 5'd6, 32'h0000_9ABC, 32'd1, 32'h0000_5678, "FWD wb");
        rd_mem = 5'd0; rd_wb = 5'd0; regwrite_mem = 1'b1; regwrite_wb = 1'b1;
        wb_data_mem = 32'h0000_1234; write_data_wb = 32'h0000_5678;
        run_op(3'd0, 5'd0, 5'd6, 32'h0000_9ABC, 32'd1, 32'h0000_9ABC, "FWD x0");
        no_fwd();

        // Flush in CALC at cycle 10
        funct3 = 3'd0; rs1 = 5'd1; rs2 = 5'd2; read_data1 = 32'd9; read_data2 = 32'd9; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        pulses = 0;
        for (int c = 1; c < 10; c++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        check_val("flush stall", stall, 0);
        @(negedge clk);
        flush = 1'b0;
        if (done) pulses++;
        check_val("flush idle stall", stall, 0);
        check_val("flush no done", pulses, 0);
        run_op(3'd5, 5'd1, 5'd2, 32'd1000, 32'd3, 32'd333, "after flush");

        // Flush while valid in IDLE: op must not be accepted
        funct3 = 3'd0; read_data1 = 32'd2; read_data2 = 32'd3; valid = 1'b1; flush = 1'b1;
        #1;
        check_val("idle flush stall", stall, 0);
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || stall) pulses++;
            @(negedge clk);
        end
        check_val("idle flush no activity", pulses, 0);

        // Asynchronous reset mid-CALC; result holds 2 from REMU beforehand
        run_op(3'd7, 5'd1, 5'd2, 32'd100, 32'd7, 32'd2, "pre reset");
        funct3 = 3'd0; read_data1 = 32'd11; read_data2 = 32'd13; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("async rst stall", stall, 0);
        check_val("async rst done", done, 0);
        check_val("async rst result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(3'd0, 5'd1, 5'd2, 32'd11, 32'd13, 32'd143, "after reset");

        // Randomized ops with random forwarding, back to back
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            d1 = pick_operand();
            d2 = pick_operand();
            rd_mem = 5'($urandom_range(0, 7));
            rd_wb = 5'($urandom_range(0, 7));
            regwrite_mem = 1'($urandom_range(0, 1));
            regwrite_wb = 1'($urandom_range(0, 1));
            wb_data_mem = pick_operand();
            write_data_wb = pick_operand();
            exp = ref_muldiv(f3, fwd_model(r1, d1), fwd_model(r2, d2));
            run_op(f3, r1, r2, d1, d2, exp, $sformatf("RND%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
